// File: rtl/fetch_issue_ctrl_if.sv
// Bundle between the fetch/issue controller, the memory arbiter and the Decoder.
//
// Handshakes:
//   memory : a byte read happens in every cycle with mem_req && mem_grant; the byte
//            for that address appears on mem_din in the next enabled cycle.
//   decoder: instr_ready/instr_out/instr_addr_out stay stable until
//            instr_ready && !issue_stall in one cycle (acceptance); the Decoder then
//            raises instr_issued with predict_pc in the cycle after acceptance.
//   flush  : rob_clear with rob_clear_pc aborts everything and restarts fetch.
interface fetch_issue_ctrl_if;
    logic        mem_req;
    logic        mem_grant;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic        issue_stall;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_addr_out;
    logic        instr_issued;
    logic [31:0] predict_pc;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;

    modport master (
        output mem_req, mem_a, instr_ready, instr_out, instr_addr_out,
        input  mem_grant, mem_din, issue_stall, instr_issued, predict_pc,
               rob_clear, rob_clear_pc
    );

    modport slave (
        input  mem_req, mem_a, instr_ready, instr_out, instr_addr_out,
        output mem_grant, mem_din, issue_stall, instr_issued, predict_pc,
               rob_clear, rob_clear_pc
    );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue controller: reads a 32-bit instruction byte by byte through the
// shared memory port, presents it to the Decoder, then follows the predicted PC.
// A RoB clear aborts any work and restarts fetch at the clear PC.
module fetch_issue_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    fetch_issue_ctrl_if.master        bus,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        PRESENT = 2'd1,
        WAIT_PC = 2'd2
    } state_t;

    state_t      state, nstate;
    logic [31:0] pc, n_pc;
    logic [2:0]  issue_cnt, n_issue;     // bytes requested and granted (0..4)
    logic [1:0]  recv_cnt, n_recv;       // bytes already captured (0..3)
    logic        byte_pending, n_pending;
    logic [23:0] ibuf, n_buf;            // bytes 0..2; byte 3 goes straight to instr_out
    logic        n_req;
    logic [31:0] n_a;
    logic        n_ready;
    logic [31:0] n_instr, n_iaddr;
    logic        grant_hit;

    assign grant_hit = bus.mem_req && bus.mem_grant;
    assign dbg_state = state;

    // Next-state and next-output computation; the RoB clear overrides everything.
    always_comb begin
        nstate    = state;
        n_pc      = pc;
        n_issue   = issue_cnt;
        n_recv    = recv_cnt;
        n_pending = 1'b0;
        n_buf     = ibuf;
        n_ready   = bus.instr_ready;
        n_instr   = bus.instr_out;
        n_iaddr   = bus.instr_addr_out;
        n_req     = 1'b0;
        n_a       = 32'd0;

        case (state)
            FETCH: begin
                if (grant_hit) begin
                    n_issue   = issue_cnt + 3'd1;
                    n_pending = 1'b1;
                end
                if (byte_pending) begin
                    if (recv_cnt == 2'd3) begin
                        n_instr = {bus.mem_din, ibuf};
                        n_iaddr = pc;
                        n_ready = 1'b1;
                        n_issue = 3'd0;
                        n_recv  = 2'd0;
                        nstate  = PRESENT;
                    end else begin
                        case (recv_cnt)
                            2'd0:    n_buf[7:0]   = bus.mem_din;
                            2'd1:    n_buf[15:8]  = bus.mem_din;
                            default: n_buf[23:16] = bus.mem_din;
                        endcase
                        n_recv = recv_cnt + 2'd1;
                    end
                end
            end
            PRESENT: begin
                if (!bus.issue_stall) begin
                    n_ready = 1'b0;
                    nstate  = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (bus.instr_issued) begin
                    n_pc   = bus.predict_pc;
                    nstate = FETCH;
                end
            end
            default: nstate = FETCH;
        endcase

        if (bus.rob_clear) begin
            n_pc      = bus.rob_clear_pc;
            n_ready   = 1'b0;
            n_issue   = 3'd0;
            n_recv    = 2'd0;
            n_pending = 1'b0;
            nstate    = FETCH;
        end

        // The request is registered, so it reflects the counters after this edge;
        // a clear forces one idle cycle so the late byte can be dropped.
        n_req = (nstate == FETCH) && (n_issue < 3'd4) && !bus.rob_clear;
        n_a   = n_pc + {29'd0, n_issue};
    end

    // State and output registers; rdy=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= FETCH;
            pc                 <= RESET_PC;
            issue_cnt          <= 3'd0;
            recv_cnt           <= 2'd0;
            byte_pending       <= 1'b0;
            ibuf               <= 24'd0;
            bus.mem_req        <= 1'b0;
            bus.mem_a          <= 32'd0;
            bus.instr_ready    <= 1'b0;
            bus.instr_out      <= 32'd0;
            bus.instr_addr_out <= 32'd0;
        end else if (rdy) begin
            state              <= nstate;
            pc                 <= n_pc;
            issue_cnt          <= n_issue;
            recv_cnt           <= n_recv;
            byte_pending       <= n_pending;
            ibuf               <= n_buf;
            bus.mem_req        <= n_req;
            bus.mem_a          <= n_a;
            bus.instr_ready    <= n_ready;
            bus.instr_out      <= n_instr;
            bus.instr_addr_out <= n_iaddr;
        end
    end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed testbench for fetch_issue_ctrl: memory model, decoder driver and
// per-feature test tasks with inline comparisons.
module tb_fetch_issue_ctrl;

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_WAIT_PC = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [1:0] dbg_state;

    fetch_issue_ctrl_if bus ();

    fetch_issue_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory model and granted-address log ----------------
    logic [7:0]  mem [0:1023];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(posedge clk) begin
        if (rdy === 1'b1 && bus.mem_req === 1'b1 && bus.mem_grant === 1'b1) begin
            bus.mem_din <= mem[bus.mem_a[9:0]];
            got_q.push_back(bus.mem_a);
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] a0, a1, a2, a3;
        a0 = a; a1 = a + 32'd1; a2 = a + 32'd2; a3 = a + 32'd3;
        return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a0[9:0]]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits until instr_ready; lat counts cycles from the caller's current cycle.
    task automatic wait_ready(output int lat, output bit timed_out);
        lat = 0;
        while (bus.instr_ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        timed_out = (bus.instr_ready !== 1'b1);
    endtask

    // Flush to pc; returns in the first cycle that requests memory.
    task automatic restart(input logic [31:0] pc);
        bus.rob_clear    = 1'b1;
        bus.rob_clear_pc = pc;
        tick();
        bus.rob_clear = 1'b0;
        got_q.delete();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1;
        bus.rob_clear = 1'b1; bus.rob_clear_pc = 32'h200;
        bus.mem_grant = 1'b1; bus.issue_stall = 1'b0;
        bus.instr_issued = 1'b0; bus.predict_pc = 32'h0; bus.mem_din = 8'h00;
        tick();
        tick();
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        n_checks++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got=%h exp=0", bus.mem_a); end
        n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.instr_ready); end
        n_checks++; if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", bus.instr_out); end
        n_checks++; if (bus.instr_addr_out !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.instr_addr_out); end
        n_checks++; if (dbg_state !== S_FETCH) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_FETCH); end
        rst = 1'b0;
        bus.rob_clear = 1'b0;
        got_q.delete();
    endtask

    task automatic test_basic();
        int lat; bit to;
        tick();
        // rst won over the simultaneous clear, so fetch begins at RESET_PC.
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL basic_first_req got=%b/%h exp=1/0", bus.mem_req, bus.mem_a); end
        wait_ready(lat, to);
        n_checks++; if (to || lat != 5) begin n_fail++; $display("FAIL basic_latency0 got=%0d exp=5", lat); end
        n_checks++; if (bus.instr_out !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_instr0 got=%h exp=00000013", bus.instr_out); end
        n_checks++; if (bus.instr_addr_out !== 32'h0) begin n_fail++; $display("FAIL basic_addr0 got=%h exp=0", bus.instr_addr_out); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_idle got=%b exp=0", bus.mem_req); end
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_addr_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL basic_mem_a[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        // accepted this cycle (stall low); Decoder reports issue next cycle
        tick();
        n_checks++; if (bus.instr_ready !== 1'b0 || dbg_state !== S_WAIT_PC) begin n_fail++; $display("FAIL basic_accept got=%b/%0d exp=0/%0d", bus.instr_ready, dbg_state, S_WAIT_PC); end
        bus.instr_issued = 1'b1; bus.predict_pc = 32'h4;
        tick();
        bus.instr_issued = 1'b0;
        got_q.delete();
        wait_ready(lat, to);
        n_checks++; if (to || lat != 5) begin n_fail++; $display("FAIL basic_latency1 got=%0d exp=5", lat); end
        n_checks++; if (bus.instr_out !== 32'h0040_0093) begin n_fail++; $display("FAIL basic_instr1 got=%h exp=00400093", bus.instr_out); end
        n_checks++; if (bus.instr_addr_out !== 32'h4) begin n_fail++; $display("FAIL basic_addr1 got=%h exp=4", bus.instr_addr_out); end
    endtask

    task automatic test_redirect();
        int lat; bit to;
        tick();
        bus.instr_issued = 1'b1; bus.predict_pc = 32'h100;
        n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL redir_ready_drop got=%b exp=0", bus.instr_ready); end
        tick();
        bus.instr_issued = 1'b0;
        got_q.delete();
        wait_ready(lat, to);
        n_checks++; if (to || lat != 5) begin n_fail++; $display("FAIL redir_latency got=%0d exp=5", lat); end
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(k));
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL redir_addr_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL redir_mem_a[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if (bus.instr_addr_out !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%h exp=100", bus.instr_addr_out); end
        n_checks++; if (bus.instr_out !== exp_word(32'h100)) begin n_fail++; $display("FAIL redir_instr got=%h exp=%h", bus.instr_out, exp_word(32'h100)); end
    endtask

    task automatic test_stall();
        int lat; bit to;
        logic [31:0] ew;
        ew = exp_word(32'h10);
        bus.issue_stall = 1'b1;
        restart(32'h10);
        wait_ready(lat, to);
        n_checks++; if (to || bus.instr_out !== ew) begin n_fail++; $display("FAIL stall_instr got=%h exp=%h", bus.instr_out, ew); end
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.instr_issued = (i == 3);
            bus.predict_pc   = 32'h300;
            n_checks++; if (bus.instr_ready !== 1'b1 || bus.instr_out !== ew || bus.instr_addr_out !== 32'h10) begin
                n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/%h/10", i, bus.instr_ready, bus.instr_out, bus.instr_addr_out, ew);
            end
        end
        bus.instr_issued = 1'b0;
        n_checks++; if (dbg_state !== S_PRESENT) begin n_fail++; $display("FAIL stall_state got=%0d exp=%0d", dbg_state, S_PRESENT); end
        bus.issue_stall = 1'b0;
        tick();
        n_checks++; if (bus.instr_ready !== 1'b0 || dbg_state !== S_WAIT_PC) begin n_fail++; $display("FAIL stall_accept got=%b/%0d exp=0/%0d", bus.instr_ready, dbg_state, S_WAIT_PC); end
        bus.instr_issued = 1'b1; bus.predict_pc = 32'h14;
        tick();
        bus.instr_issued = 1'b0;
        n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_no_reissue got=%b exp=0", bus.instr_ready); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'h14) begin n_fail++; $display("FAIL stall_next_pc got=%b/%h exp=1/14", bus.mem_req, bus.mem_a); end
    endtask

    task automatic test_grant_gap();
        int lat; bit to;
        restart(32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.mem_grant = 1'b0;
            n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'h21) begin n_fail++; $display("FAIL gap_hold[%0d] got=%b/%h exp=1/21", i, bus.mem_req, bus.mem_a); end
        end
        tick();
        bus.mem_grant = 1'b1;
        wait_ready(lat, to);
        lat = lat + 4;
        n_checks++; if (to || lat != 8) begin n_fail++; $display("FAIL gap_latency got=%0d exp=8", lat); end
        n_checks++; if (bus.instr_out !== exp_word(32'h20)) begin n_fail++; $display("FAIL gap_instr got=%h exp=%h", bus.instr_out, exp_word(32'h20)); end
    endtask

    task automatic test_rob_clear();
        int lat; bit to;
        restart(32'h30);
        tick();
        tick();
        tick();
        n_checks++; if (bus.mem_a !== 32'h33) begin n_fail++; $display("FAIL clr_pre_a got=%h exp=33", bus.mem_a); end
        bus.rob_clear = 1'b1; bus.rob_clear_pc = 32'h200;
        tick();
        bus.rob_clear = 1'b0;
        got_q.delete();
        n_checks++; if (bus.mem_req !== 1'b0 || dbg_state !== S_FETCH) begin n_fail++; $display("FAIL clr_idle got=%b/%0d exp=0/%0d", bus.mem_req, dbg_state, S_FETCH); end
        tick();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'h200) begin n_fail++; $display("FAIL clr_restart got=%b/%h exp=1/200", bus.mem_req, bus.mem_a); end
        wait_ready(lat, to);
        n_checks++; if (to || lat != 5) begin n_fail++; $display("FAIL clr_latency got=%0d exp=5", lat); end
        n_checks++; if (bus.instr_addr_out !== 32'h200) begin n_fail++; $display("FAIL clr_addr got=%h exp=200", bus.instr_addr_out); end
        n_checks++; if (bus.instr_out !== exp_word(32'h200)) begin n_fail++; $display("FAIL clr_instr got=%h exp=%h", bus.instr_out, exp_word(32'h200)); end
    endtask

    task automatic test_rdy_freeze();
        int lat; bit to;
        restart(32'h40);
        tick();
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'h42 || dbg_state !== S_FETCH) begin
                n_fail++; $display("FAIL freeze[%0d] got=%b/%h/%0d exp=1/42/%0d", i, bus.mem_req, bus.mem_a, dbg_state, S_FETCH);
            end
        end
        rdy = 1'b1;
        wait_ready(lat, to);
        lat = lat + 6;
        n_checks++; if (to || lat != 9) begin n_fail++; $display("FAIL freeze_latency got=%0d exp=9", lat); end
        n_checks++; if (bus.instr_out !== exp_word(32'h40) || bus.instr_addr_out !== 32'h40) begin
            n_fail++; $display("FAIL freeze_instr got=%h/%h exp=%h/40", bus.instr_out, bus.instr_addr_out, exp_word(32'h40));
        end
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL freeze_addr_count got=%0d exp=4", got_q.size()); end
    endtask

    task automatic test_unaligned_wrap();
        int lat; bit to;
        restart(32'hFFFF_FFFE);
        wait_ready(lat, to);
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);         exp_q.push_back(32'h1);
        n_checks++; if (to || got_q.size() != 4) begin n_fail++; $display("FAIL wrap_addr_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL wrap_mem_a[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if (bus.instr_out !== {8'h00, 8'h13, mem[1023], mem[1022]}) begin
            n_fail++; $display("FAIL wrap_instr got=%h exp=%h", bus.instr_out, {8'h00, 8'h13, mem[1023], mem[1022]});
        end
        n_checks++; if (bus.instr_addr_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_addr got=%h exp=fffffffe", bus.instr_addr_out); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3) ^ 8'hA5;
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h40; mem[7] = 8'h00;

        test_reset();
        test_basic();
        test_redirect();
        test_stall();
        test_grant_gap();
        test_rob_clear();
        test_rdy_freeze();
        test_unaligned_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
- Sequences instruction delivery into the Decoder.
- Reads each 32-bit instruction byte-serially through a shared memory port, arbitrated externally via req/grant.
- Presents the instruction to the Decoder, waits for the issue handshake, then redirects fetch to the Decoder's predicted PC.
- Aborts and restarts on a RoB clear. Sits between the memory arbiter and the Decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global enable; 0 freezes all state
- mem_req  output  1  request for the memory port this cycle
- mem_grant  input  1  arbiter grants the port this cycle; only meaningful with mem_req=1
- mem_a  output  32  byte address; valid when mem_req=1
- mem_din  input  8  read byte for the address granted in the previous enabled cycle
- issue_stall  input  1  OR of rob_full, rs_full and lsb_full (combinational)
- instr_ready  output  1  instr_out/instr_addr_out valid for the Decoder
- instr_out  output  32  assembled instruction
- instr_addr_out  output  32  PC of instr_out
- instr_issued  input  1  Decoder's registered issue flag (cycle after acceptance)
- predict_pc  input  32  next PC from the Decoder; valid when instr_issued=1
- rob_clear  input  1  flush request from RoB
- rob_clear_pc  input  32  restart PC; valid when rob_clear=1

Behaviour:
- Reset (rst=1 at posedge), regardless of state:
  - pc=RESET_PC; state=FETCH; issue_cnt=0; recv_cnt=0; byte_pending=0.
  - mem_req=0, mem_a=0, instr_ready=0, instr_out=0, instr_addr_out=0.
  - Reset mid-fetch discards any in-flight byte.
- rdy=0: no state, counter or output changes. Memory holds mem_din across rdy=0, so a pending byte is sampled on the first rdy=1 cycle.
- States: FETCH, PRESENT, WAIT_PC.
- FETCH:
  - mem_req=1 while issue_cnt<4; mem_a=pc+issue_cnt, 32-bit wrap.
  - Each mem_req&&mem_grant cycle: issue_cnt++ and byte_pending<=1.
  - Cycle after a grant: mem_din is stored into buf[8*recv_cnt +: 8] (little-endian), recv_cnt++.
  - Loss of grant mid-fetch pauses issue only; the byte from the last grant is still captured.
  - When the 4th byte is captured: instr_out<={byte3,byte2,byte1,byte0}, instr_addr_out=pc, instr_ready<=1, issue_cnt=recv_cnt=0, state=PRESENT.
  - mem_req is 0 the cycle after issue_cnt reaches 4.
  - Minimum latency: FETCH entry to instr_ready = 5 cycles with continuous grant.
- PRESENT:
  - Acceptance is instr_ready && !issue_stall in the same cycle; then instr_ready<=0, state=WAIT_PC.
  - With issue_stall=1, hold instr_ready and data stable indefinitely.
  - instr_ready is never high in the cycle the Decoder reports instr_issued, so no double issue is possible.
- WAIT_PC:
  - On instr_issued=1: pc<=predict_pc, state=FETCH; the fetch starts next cycle.
  - instr_issued never arrives later than the cycle after acceptance; any other instr_issued pulse is ignored.
- rob_clear=1, highest priority, any state:
  - pc<=rob_clear_pc; instr_ready<=0; mem_req<=0 that edge; issue_cnt=recv_cnt=0; byte_pending=0; state=FETCH.
  - A byte arriving the cycle after the clear is discarded.
  - A simultaneous instr_issued or grant is ignored.
  - Simultaneous rst wins over rob_clear.
- Unaligned PC is legal; bytes are fetched from pc..pc+3 verbatim.

Test Plan:
- Reset, continuous grant, memory words 0x00000013 at 0 and 0x00400093 at 4; accept each with predict_pc=prev+4 -> instr_ready rises at cycle 5 with instr_out=0x00000013 and addr 0; the second word is presented with addr 4; mem_a sequence is 0,1,2,3.
- Grant withheld for 3 cycles after byte 1 -> mem_a holds at pc+1; instr_out is still assembled correctly; latency is 8 cycles.
- issue_stall=1 for 10 cycles in PRESENT -> instr_ready and data are stable; acceptance occurs on the first stall=0 cycle; instr_ready drops next cycle; no second acceptance.
- instr_issued with predict_pc=0x100 (a JAL target) -> next mem_a=0x100, 0x101, 0x102, 0x103.
- rob_clear with rob_clear_pc=0x200 while recv_cnt=2 and a byte is in flight -> the in-flight byte is dropped; fetch restarts at 0x200; instr_addr_out=0x200 at the next presentation.
- rdy=0 for 4 cycles mid-fetch, then rdy=1 -> the same instruction results as with no stall; counters are unchanged during the freeze.
